// File: rtl/fft_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buffer_if
// Description : Bundles the sample-capture inputs, the frame handshake and the
//               random-access read port of fft_frame_buffer.
//               slave  - seen by the frame buffer
//               master - seen by the producer / FFT loader side
// Ports       : left, right     24-bit signed samples from the I2S receiver
//               newsample       1-cycle capture strobe
//               chan_sel        channel selection (left/right/mix)
//               rd_adr, rd_data read port into the ready frame
//               frame_rdy, frame_ack, overrun  frame handshake and status
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_frame_buffer_if #(
  parameter int N_LOG2 = 5
);
  logic [23:0]       left;
  logic [23:0]       right;
  logic              newsample;
  logic [1:0]        chan_sel;
  logic [N_LOG2-1:0] rd_adr;
  logic [31:0]       rd_data;
  logic              frame_rdy;
  logic              frame_ack;
  logic              overrun;

  modport slave (
    input  left, right, newsample, chan_sel, rd_adr, frame_ack,
    output rd_data, frame_rdy, overrun
  );

  modport master (
    output left, right, newsample, chan_sel, rd_adr, frame_ack,
    input  rd_data, frame_rdy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_buffer
// Description : Ping-pong frame store between the I2S receiver and the FFT
//               core. One mono sample is captured per newsample strobe and
//               packed as {sample16, 16'h0000}. N = 2**N_LOG2 samples form a
//               frame; a completed frame is handed to the FFT loader through
//               frame_rdy/frame_ack and a registered read port.
// Ports       : clk    - system clock
//               reset  - synchronous, active-high reset
//               bus    - fft_frame_buffer_if.slave (capture inputs, read
//                        port, frame_rdy/frame_ack handshake, sticky overrun)
// Parameters  : N_LOG2 - log2 of the frame length
//               BITREV - 1: samples written at bit-reversed addresses
//                        0: samples written in natural order
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_buffer #(
  parameter int N_LOG2 = 5,
  parameter bit BITREV = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  fft_frame_buffer_if.slave   bus
);

  localparam int                c_n        = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] c_last_ptr = '1;

  // Two banks of N 16-bit samples; bank select is the address MSB.
  logic [15:0]       r_mem [0:2*c_n-1];

  logic              r_pending;
  logic [N_LOG2-1:0] r_wr_ptr;
  logic              r_wr_bank;     // read bank is always the other one
  logic              r_frame_rdy;
  logic              r_overrun;
  logic [31:0]       r_rd_data;

  logic [N_LOG2-1:0] w_wr_addr;
  logic              w_mix_carry;
  logic [15:0]       w_mix;
  logic [15:0]       w_sample;
  logic              w_frame_done;
  logic              w_swap;

  // --------------------------------------------------------------------------
  // Write address ordering
  // --------------------------------------------------------------------------
  generate
    if (BITREV) begin : g_bitrev
      for (genvar i = 0; i < N_LOG2; i++) begin : g_bit
        assign w_wr_addr[i] = r_wr_ptr[N_LOG2-1-i];
      end
    end else begin : g_natural
      assign w_wr_addr = r_wr_ptr;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Sample formation
  // Mono mix = bits [23:8] of ((left + right) >>> 1), i.e. bits [24:9] of the
  // 25-bit sum. The sum is split at bit 9: the upper parts are added directly
  // and the carry out of the low 9 bits is injected. That carry is set exactly
  // when left[8:0] + right[8:0] >= 512, i.e. left[8:0] > ~right[8:0].
  // The true result always fits in 16 signed bits, so the 16-bit wrap is exact.
  // --------------------------------------------------------------------------
  assign w_mix_carry = (bus.left[8:0] > ~bus.right[8:0]);
  assign w_mix = {bus.left[23],  bus.left[23:9]}
               + {bus.right[23], bus.right[23:9]}
               + {15'd0, w_mix_carry};

  always_comb begin
    w_sample = bus.left[23:8];
    case (bus.chan_sel)
      2'b01:   w_sample = bus.right[23:8];
      2'b10:   w_sample = w_mix;
      default: w_sample = bus.left[23:8];
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame control
  // A capture happens on the cycle after newsample (r_pending). The capture
  // that writes slot N-1 completes the frame; it swaps banks only if the read
  // bank is free or being released in this very cycle.
  // --------------------------------------------------------------------------
  assign w_frame_done = r_pending && (r_wr_ptr == c_last_ptr);
  assign w_swap       = w_frame_done && (!r_frame_rdy || bus.frame_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= 1'b0;
      r_wr_ptr    <= '0;
      r_wr_bank   <= 1'b0;
      r_frame_rdy <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_pending <= bus.newsample;

      if (r_pending) begin
        r_wr_ptr <= r_wr_ptr + N_LOG2'(1);   // wraps to 0 after slot N-1
      end

      if (w_swap) begin
        r_wr_bank   <= ~r_wr_bank;
        r_frame_rdy <= 1'b1;
      end else if (w_frame_done) begin
        // Read bank still held: drop this frame, keep the ready one intact.
        r_overrun <= 1'b1;
      end else if (bus.frame_ack) begin
        r_frame_rdy <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame store (no reset so it can map onto RAM)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_pending && !reset) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= w_sample;
    end
  end

  // Registered read port; the bank select follows a swap on the same edge as
  // frame_rdy, so the read issued when frame_rdy rises sees the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= {r_mem[{~r_wr_bank, bus.rd_adr}], 16'h0000};
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.frame_rdy = r_frame_rdy;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_buffer
// Description : Self-checking bench for fft_frame_buffer. Two instances are
//               driven with identical stimulus, one with BITREV=1 and one with
//               BITREV=0. A frame-level reference model predicts the ready
//               frame, frame_rdy and overrun; read responses are checked by a
//               scoreboard monitor decoupled from the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_buffer;

  localparam int N_LOG2 = 5;
  localparam int N      = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [23:0]       s_left  = '0;
  logic [23:0]       s_right = '0;
  logic              s_ns    = 1'b0;
  logic [1:0]        s_cs    = '0;
  logic [N_LOG2-1:0] s_adr   = '0;
  logic              s_ack   = 1'b0;

  fft_frame_buffer_if #(.N_LOG2(N_LOG2)) bus0 ();
  fft_frame_buffer_if #(.N_LOG2(N_LOG2)) bus1 ();

  assign bus0.left = s_left;   assign bus1.left = s_left;
  assign bus0.right = s_right; assign bus1.right = s_right;
  assign bus0.newsample = s_ns; assign bus1.newsample = s_ns;
  assign bus0.chan_sel = s_cs; assign bus1.chan_sel = s_cs;
  assign bus0.rd_adr = s_adr;  assign bus1.rd_adr = s_adr;
  assign bus0.frame_ack = s_ack; assign bus1.frame_ack = s_ack;

  fft_frame_buffer #(.N_LOG2(N_LOG2), .BITREV(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  fft_frame_buffer #(.N_LOG2(N_LOG2), .BITREV(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the frame being filled (arrival order), the
  // frame handed to the consumer (arrival order), and the two status flags.
  logic [15:0] m_cur [$];
  logic [15:0] m_ready [N];
  bit          m_rdy = 1'b0;
  bit          m_ovr = 1'b0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic        rd_issue = 1'b0;
  logic        rd_vld   = 1'b0;

  function automatic int bitrev(input int a);
    logic [4:0] x, y;
    x = a[4:0];
    for (int i = 0; i < 5; i++) y[i] = x[4-i];
    return int'(y);
  endfunction

  function automatic logic [15:0] model_sample(input logic [23:0] l,
                                               input logic [23:0] r,
                                               input logic [1:0] cs);
    int li, ri, v;
    li = int'($signed(l));
    ri = int'($signed(r));
    case (cs)
      2'b01:   v = ri >>> 8;
      2'b10:   v = (li + ri) >>> 9;
      default: v = li >>> 8;
    endcase
    return v[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string nm);
    chk({nm, " frame_rdy0"}, {31'd0, bus0.frame_rdy}, {31'd0, m_rdy});
    chk({nm, " frame_rdy1"}, {31'd0, bus1.frame_rdy}, {31'd0, m_rdy});
    chk({nm, " overrun0"},   {31'd0, bus0.overrun},   {31'd0, m_ovr});
    chk({nm, " overrun1"},   {31'd0, bus1.overrun},   {31'd0, m_ovr});
  endtask

  // Scoreboard monitor: one response per issued read, one cycle later.
  always @(posedge clk) rd_vld <= rd_issue;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_scoreboard: response with no expectation (t=%0t)", $time);
      end else begin
        chk("rd_data0", bus0.rd_data, q0.pop_front());
        chk("rd_data1", bus1.rd_data, q1.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s_ns = 1'b0; s_ack = 1'b0; rd_issue = 1'b0;
    repeat (2) @(negedge clk);
    m_cur.delete(); m_rdy = 1'b0; m_ovr = 1'b0;
    chk("reset rd_data0", bus0.rd_data, 32'h0);
    chk("reset rd_data1", bus1.rd_data, 32'h0);
    chk_status("reset");
    reset = 1'b0;
  endtask

  // One capture: strobe, then the capture cycle (with optional ack), then
  // check the status one cycle after the capture edge.
  task automatic send(input logic [23:0] l, input logic [23:0] r,
                      input logic [1:0] cs, input bit ack);
    @(negedge clk);
    s_left = l; s_right = r; s_cs = cs; s_ns = 1'b1;
    @(negedge clk);
    s_ns = 1'b0; s_ack = ack;
    chk_status("pre-capture");
    m_cur.push_back(model_sample(l, r, cs));
    if (m_cur.size() == N) begin
      if (!m_rdy || ack) begin
        for (int i = 0; i < N; i++) m_ready[i] = m_cur[i];
        m_rdy = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      m_cur.delete();
    end else if (ack) begin
      m_rdy = 1'b0;
    end
    @(negedge clk);
    s_ack = 1'b0;
    chk_status("post-capture");
  endtask

  task automatic fill_random(input bit ack_last);
    for (int k = 0; k < N; k++)
      send(24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)), ack_last && (k == N-1));
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    m_rdy = 1'b0;
    chk_status("ack");
  endtask

  // Issue one read. use_const replaces the model value for the BITREV=1 DUT.
  task automatic rd(input int a, input bit use_const, input logic [31:0] c0);
    @(negedge clk);
    s_adr = N_LOG2'(a);
    rd_issue = 1'b1;
    q0.push_back(use_const ? c0 : {m_ready[bitrev(a)], 16'h0000});
    q1.push_back({m_ready[a], 16'h0000});
  endtask

  task automatic rd_end();
    @(negedge clk);
    rd_issue = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) rd(a, 1'b0, 32'h0);
    rd_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    do_reset();

    // Ack with nothing ready is ignored.
    ack_pulse();

    // Left ramp, known answers for the bit-reversed instance.
    for (int k = 0; k < N; k++) send(24'(k << 8), 24'($urandom), 2'b00, 1'b0);
    rd(1,  1'b1, 32'h0010_0000);
    rd(31, 1'b1, 32'h001F_0000);
    rd_end();
    read_all();
    ack_pulse();

    // Frame A: mix extremes first, then random.
    send(24'h7FFFFF, 24'h7FFFFF, 2'b10, 1'b0);
    send(24'h800000, 24'h7FFFFF, 2'b10, 1'b0);
    for (int k = 2; k < N; k++)
      send(24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    rd(0,  1'b1, 32'h7FFF_0000);
    rd(16, 1'b1, 32'hFFFF_0000);
    rd_end();
    read_all();
    ack_pulse();

    // Frame B held, frame C dropped.
    fill_random(1'b0);
    read_all();
    fill_random(1'b0);
    read_all();

    // Ack coincident with the last write of a new frame.
    do_reset();
    fill_random(1'b0);
    read_all();
    fill_random(1'b1);
    read_all();

    // Reset in the middle of a frame.
    for (int k = 0; k < 10; k++)
      send(24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    do_reset();
    fill_random(1'b0);
    read_all();
    ack_pulse();

    // Right ramp.
    for (int k = 0; k < N; k++) send(24'($urandom), 24'(k << 8), 2'b01, 1'b0);
    read_all();
    ack_pulse();

    // A couple of random frames with release in between.
    for (int f = 0; f < 2; f++) begin
      fill_random(1'b0);
      read_all();
      ack_pulse();
    end

    for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rd_drain: %0d/%0d responses outstanding, expected 0", q0.size(), q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Sits directly downstream of the I2S receiver and upstream of the FFT core.
- Captures one mono sample per `newsample` strobe from the 24-bit left/right outputs and packs it as a 32-bit complex word (real = 16-bit sample, imag = 0).
- Accumulates N words into a ping-pong (double-buffered) frame store.
- Hands a completed frame to the FFT loader through a ready/ack handshake and a registered random-access read port.

Parameters:
- N_LOG2, 5, log2 of frame length (N = 32 points).
- BITREV, 1, 1 = write samples at bit-reversed addresses (FFT in-place input order); 0 = natural order.

Ports:
- clk  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high reset.
- left  in  24  signed left sample from the I2S receiver.
- right  in  24  signed right sample from the I2S receiver.
- newsample  in  1  1-cycle strobe; left/right are valid on the cycle after it (receiver output register update).
- chan_sel  in  2  00 = left, 01 = right, 10 = mono mix, 11 = left.
- rd_adr  in  N_LOG2  read address into the ready frame.
- rd_data  out  32  {sample16, 16'h0000} at rd_adr; 1-cycle latency.
- frame_rdy  out  1  a complete frame is held in the read bank.
- frame_ack  in  1  1-cycle pulse from the consumer: frame consumed, read bank released.
- overrun  out  1  sticky: a frame was dropped because the read bank was still held.

Behaviour:
- Reset values: `rd_data` = 0, `frame_rdy` = 0, `overrun` = 0. Internally: `wr_ptr` = 0, write bank = 0, read bank = 1, capture-pending flag = 0.
- Reset mid-frame discards the partial frame and any ready frame.
- Capture timing:
  - `newsample` sets a pending flag.
  - On the following cycle, `left`/`right` are sampled and the pending flag clears.
  - `chan_sel` is sampled on that same cycle.
- Sample formation:
  - Left: `left[23:8]`. Right: `right[23:8]`.
  - Mix: 25-bit signed sum `left + right`, arithmetic shift right 1, then bits [23:8]. No saturation is needed; the result always fits.
- Write address: `BITREV ? bitreverse(wr_ptr) : wr_ptr` into the write bank; `wr_ptr` then increments.
- Frame completion is the write with `wr_ptr == N-1`; `wr_ptr` wraps to 0 on that cycle. Then:
  - If `frame_rdy == 0`, or `frame_ack` is asserted in the same cycle: swap banks; `frame_rdy` = 1 on the next cycle.
  - Otherwise (consumer still holds the read bank): no swap; `overrun` = 1 (sticky until reset); the write bank is overwritten by the next frame; the current `frame_rdy` frame stays intact.
- `frame_ack` with no simultaneous completion: `frame_rdy` = 0 on the next cycle.
- `frame_ack` while `frame_rdy == 0`: ignored.
- Read port:
  - `rd_data` is registered from the read bank at `rd_adr`, one cycle of latency.
  - Contents are stable while `frame_rdy == 1`.
  - After a bank swap, reads return the new frame starting from the cycle `frame_rdy` rises.
- Storage: 2 × N × 16 bits. The imaginary half is a constant 0 and is not stored. Either flops or inferred RAM is acceptable, provided the 1-cycle read latency holds.
- Write throughput: one sample per `newsample` (every 256 clk). Back-to-back strobes one cycle apart are not required to be supported.

Test Plan:
- Reset, then 32 strobes with `chan_sel` = 00 and `left` = k<<8 (k = 0..31), BITREV = 1:
  - `frame_rdy` rises 2 cycles after the 32nd strobe.
  - Reading `rd_adr` = 1 returns 32'h0010_0000 (sample 16).
  - Reading `rd_adr` = 31 returns 32'h001F_0000.
- Mix mode, `left` = 24'h7FFFFF, `right` = 24'h7FFFFF → word 32'h7FFF_0000. Mix mode, `left` = 24'h800000, `right` = 24'h7FFFFF → 32'hFFFF_0000.
- Fill frame A and ack, then fill frame B without ack, then fill frame C without ack:
  - `overrun` goes 1 at C's completion.
  - Reads still return frame B data.
  - `frame_rdy` stays 1.
- Assert `frame_ack` on the exact cycle of the 32nd write while a frame is ready: `frame_rdy` stays 1, `overrun` stays 0, and the read data switches to the new frame.
- Assert reset after 10 writes, then write 32 samples: the first ready frame contains only post-reset samples, and `overrun` = 0.
- BITREV = 0, right channel with `right` = k<<8 → `rd_adr` = k returns {k[15:0], 16'h0} for all k.
